uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 12 +
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// CPU-side read port of the UART receiver: FIFO pop, error clear and status.
interface uart_rx_fifo_if;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;

  modport master (output rd_en, err_clr, input rd_data, rx_valid, overrun, frame_err);
  modport slave  (input rd_en, err_clr, output rd_data, rx_valid, overrun, frame_err);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word fall-through
// receive FIFO with sticky overrun and framing-error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          CLK100MHZ,
  input  logic          rst_n,
  input  logic          uart_txd_in,
  uart_rx_fifo_if.slave cpu
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] HALF_BIT  = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;

  rx_state_t        state, state_next;
  logic             sync1, sync2, line_d;
  logic [15:0]      timer, timer_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             push, stop_bad;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overrun_q, frame_err_q;
  logic             pop, full, wr_accept, drop;

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_d    <= 1'b1;
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      sync1     <= uart_txd_in;
      sync2     <= sync1;
      line_d    <= sync2;
      state     <= state_next;
      timer     <= timer_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

  // Start edge is a registered high-to-low on the synchronized line; the
  // half-bit recheck in START rejects glitches shorter than half a bit.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    push         = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (line_d && !sync2) begin
          state_next = START;
          timer_next = '0;
        end
      end
      START: begin
        if (timer == HALF_BIT) begin
          timer_next = '0;
          if (!sync2) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer + 16'd1;
        end
      end
      DATA: begin
        if (timer == LAST_TICK) begin
          timer_next   = '0;
          shift_next   = {sync2, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end else begin
          timer_next = timer + 16'd1;
        end
      end
      STOP: begin
        if (timer == LAST_TICK) begin
          timer_next = '0;
          if (sync2) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          timer_next = timer + 16'd1;
        end
      end
      WAIT_IDLE: begin
        if (sync2) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept
  // whenever it coincides with a read.
  assign pop       = cpu.rd_en && (count != '0);
  assign full      = (count == FULL_CNT);
  assign wr_accept = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge CLK100MHZ) begin
    if (wr_accept) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)             overrun_q <= 1'b1;
      else if (cpu.err_clr) overrun_q <= 1'b0;
      if (stop_bad)         frame_err_q <= 1'b1;
      else if (cpu.err_clr) frame_err_q <= 1'b0;
    end
  end

  assign cpu.rx_valid  = (count != '0);
  assign cpu.rd_data   = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign cpu.overrun   = overrun_q;
  assign cpu.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO:
// table-driven CPU read/clear vectors plus hand-timed serial frames.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic CLK100MHZ = 1'b0;
  logic rst_n;
  logic uart_txd_in;
  int   checks   = 0;
  int   failures = 0;

  uart_rx_fifo_if cpu ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .CLK100MHZ  (CLK100MHZ),
    .rst_n      (rst_n),
    .uart_txd_in(uart_txd_in),
    .cpu        (cpu)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic       rd_en;
    logic       err_clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_overrun;
    logic       exp_frame;
  } vec_t;

  vec_t vecs [8];

  task automatic cyc();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic [7:0] d, input logic ov, input logic fe);
    checkOutput($sformatf("%s rx_valid", tag),  {7'd0, cpu.rx_valid},  {7'd0, v});
    checkOutput($sformatf("%s rd_data", tag),   cpu.rd_data,           d);
    checkOutput($sformatf("%s overrun", tag),   {7'd0, cpu.overrun},   {7'd0, ov});
    checkOutput($sformatf("%s frame_err", tag), {7'd0, cpu.frame_err}, {7'd0, fe});
  endtask

  task automatic applyStimulus(input logic rd, input logic clr);
    cpu.rd_en   = rd;
    cpu.err_clr = clr;
    cyc();
    cpu.rd_en   = 1'b0;
    cpu.err_clr = 1'b0;
  endtask

  // Start bit plus eight data bits, LSB first; leaves the line at bit 7.
  task automatic sendBits(input logic [7:0] b);
    uart_txd_in = 1'b0;
    repeat (CPB) cyc();
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = b[i];
      repeat (CPB) cyc();
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendBits(b);
    uart_txd_in = 1'b1;
    repeat (CPB + 4) cyc();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n       = 1'b0;
    uart_txd_in = 1'b1;
    cpu.rd_en   = 1'b0;
    cpu.err_clr = 1'b0;
    repeat (3) cyc();
    checkAll("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) cyc();

    // Stop sample lands 156 edges after the start edge; byte appears after it.
    $display("[TB] single byte A5");
    sendBits(8'hA5);
    uart_txd_in = 1'b1;
    repeat (11) cyc();
    checkAll("A5 before stop", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    checkAll("A5 after stop", 1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (8) cyc();
    applyStimulus(1'b1, 1'b0);
    checkAll("A5 popped", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] overrun with five bytes");
    for (int i = 1; i <= 5; i++) sendByte(8'(i));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rd_en, vecs[i].err_clr);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
               vecs[i].exp_overrun, vecs[i].exp_frame);
    end

    // Framing error coinciding with err_clr: the error must still be set.
    $display("[TB] framing error 3C");
    sendBits(8'h3C);
    uart_txd_in = 1'b0;
    repeat (11) cyc();
    cpu.err_clr = 1'b1;
    cyc();
    cpu.err_clr = 1'b0;
    checkAll("3C bad stop", 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (12) cyc();
    uart_txd_in = 1'b1;
    repeat (8) cyc();
    sendByte(8'h7E);
    checkAll("7E after break", 1'b1, 8'h7E, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkAll("frame_err cleared", 1'b1, 8'h7E, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkAll("7E popped", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] short glitch");
    uart_txd_in = 1'b0;
    repeat (4) cyc();
    uart_txd_in = 1'b1;
    repeat (30) cyc();
    checkAll("glitch", 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'hC3);
    checkAll("C3 after glitch", 1'b1, 8'hC3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] push and pop on full FIFO");
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    sendByte(8'h44);
    checkAll("full head", 1'b1, 8'h11, 1'b0, 1'b0);
    sendBits(8'h99);
    uart_txd_in = 1'b1;
    repeat (11) cyc();
    cpu.rd_en = 1'b1;
    cyc();
    cpu.rd_en = 1'b0;
    checkAll("push+pop full", 1'b1, 8'h22, 1'b0, 1'b0);
    repeat (8) cyc();
    applyStimulus(1'b1, 1'b0);
    checkAll("read 33", 1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkAll("read 44", 1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkAll("read 99", 1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkAll("drained", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset during data bit 3 of an all-ones frame, with a byte already queued.
    $display("[TB] reset mid-frame");
    sendByte(8'h42);
    checkAll("42 queued", 1'b1, 8'h42, 1'b0, 1'b0);
    uart_txd_in = 1'b0;
    repeat (CPB) cyc();
    uart_txd_in = 1'b1;
    repeat (CPB * 3 + 8) cyc();
    rst_n = 1'b0;
    repeat (3) cyc();
    checkAll("mid-frame reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (200) cyc();
    checkAll("aborted frame", 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'h5A);
    checkAll("5A after reset", 1'b1, 8'h5A, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
